// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, multi-port writeback, in-order
// single retire per cycle, bypassed operand lookup and single-cycle flush.
module rob_param #(
  parameter int ROB_W    = 4,
  parameter int WB_PORTS = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         issue_valid,
  input  logic [ADDR_W-1:0]            issue_pc,
  input  logic [6:0]                   issue_opcode,
  input  logic [REG_W-1:0]             issue_rd,
  input  logic                         issue_pre_j,
  output logic [ROB_W-1:0]             issue_tag,
  output logic                         full,
  output logic                         empty,
  output logic [ROB_W:0]               count,
  output logic [ROB_W-1:0]             head_tag,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*ROB_W-1:0]    wb_tag,
  input  logic [WB_PORTS*DATA_W-1:0]   wb_val,
  input  logic [WB_PORTS-1:0]          wb_j,
  input  logic [WB_PORTS*ADDR_W-1:0]   wb_pc,
  input  logic [ROB_W-1:0]             q1_tag,
  input  logic [ROB_W-1:0]             q2_tag,
  output logic                         q1_ready,
  output logic                         q2_ready,
  output logic [DATA_W-1:0]            q1_val,
  output logic [DATA_W-1:0]            q2_val,
  output logic                         commit_reg,
  output logic [REG_W-1:0]             commit_rd,
  output logic [DATA_W-1:0]            commit_val,
  output logic [ROB_W-1:0]             commit_tag,
  output logic                         commit_store,
  output logic                         commit_br,
  output logic                         commit_br_j,
  output logic [ADDR_W-1:0]            commit_br_pc,
  output logic                         rollback,
  output logic [ADDR_W-1:0]            rollback_pc
);
  localparam int DEPTH = 2**ROB_W;
  localparam logic [ROB_W:0] DEPTH_C = (ROB_W+1)'(DEPTH);
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  logic [DEPTH-1:0]  busy, ready, res_j, pre_j;
  logic [ADDR_W-1:0] pc     [DEPTH];
  logic [ADDR_W-1:0] res_pc [DEPTH];
  logic [DATA_W-1:0] val    [DEPTH];
  logic [6:0]        opcode [DEPTH];
  logic [REG_W-1:0]  rd     [DEPTH];
  logic [ROB_W-1:0]  head, tail;
  logic              issue_ok, commit_ok, head_flush;

  assign issue_tag = tail;
  assign head_tag  = head;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign issue_ok  = rdy && issue_valid && !full && !rollback;
  assign commit_ok = rdy && !empty && busy[head] && ready[head] && !rollback;

  always_comb begin
    head_flush = 1'b0;
    if (opcode[head] == OP_B)         head_flush = (res_j[head] != pre_j[head]);
    else if (opcode[head] == OP_JALR) head_flush = 1'b1;
  end

  // Ports are scanned highest-first so the lowest matching port is applied last.
  always_comb begin
    q1_ready = ready[q1_tag];
    q1_val   = val[q1_tag];
    q2_ready = ready[q2_tag];
    q2_val   = val[q2_tag];
    for (int unsigned i = 0; i < WB_PORTS; i++) begin
      if (wb_valid[WB_PORTS-1-i] && wb_tag[(WB_PORTS-1-i)*ROB_W +: ROB_W] == q1_tag) begin
        q1_ready = 1'b1;
        q1_val   = wb_val[(WB_PORTS-1-i)*DATA_W +: DATA_W];
      end
      if (wb_valid[WB_PORTS-1-i] && wb_tag[(WB_PORTS-1-i)*ROB_W +: ROB_W] == q2_tag) begin
        q2_ready = 1'b1;
        q2_val   = wb_val[(WB_PORTS-1-i)*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0; tail <= '0; count <= '0;
      busy <= '0; ready <= '0;
      val <= '{default: '0};
      commit_reg <= 1'b0; commit_rd <= '0; commit_val <= '0; commit_tag <= '0;
      commit_store <= 1'b0; commit_br <= 1'b0; commit_br_j <= 1'b0; commit_br_pc <= '0;
      rollback <= 1'b0; rollback_pc <= '0;
    end else if (rdy) begin
      commit_reg <= 1'b0; commit_store <= 1'b0; commit_br <= 1'b0; rollback <= 1'b0;
      if (!rollback) begin
        for (int unsigned i = 0; i < WB_PORTS; i++) begin
          if (wb_valid[WB_PORTS-1-i]) begin
            ready[wb_tag[(WB_PORTS-1-i)*ROB_W +: ROB_W]]  <= 1'b1;
            val[wb_tag[(WB_PORTS-1-i)*ROB_W +: ROB_W]]    <= wb_val[(WB_PORTS-1-i)*DATA_W +: DATA_W];
            res_j[wb_tag[(WB_PORTS-1-i)*ROB_W +: ROB_W]]  <= wb_j[WB_PORTS-1-i];
            res_pc[wb_tag[(WB_PORTS-1-i)*ROB_W +: ROB_W]] <= wb_pc[(WB_PORTS-1-i)*ADDR_W +: ADDR_W];
          end
        end
      end
      if (commit_ok) begin
        busy[head] <= 1'b0;
        head       <= head + 1'b1;
        commit_tag <= head;
        commit_rd  <= rd[head];
        commit_val <= val[head];
        if (opcode[head] == OP_S) begin
          commit_store <= 1'b1;
        end else if (opcode[head] == OP_B) begin
          commit_br    <= 1'b1;
          commit_br_j  <= res_j[head];
          commit_br_pc <= pc[head];
        end else begin
          commit_reg <= 1'b1;
        end
        if (head_flush) begin
          rollback    <= 1'b1;
          rollback_pc <= res_pc[head];
        end
      end
      // Issue follows writeback so a same-index allocation overrides stale results.
      if (issue_ok) begin
        busy[tail]   <= 1'b1;
        ready[tail]  <= (issue_opcode == OP_S);
        pc[tail]     <= issue_pc;
        opcode[tail] <= issue_opcode;
        rd[tail]     <= issue_rd;
        pre_j[tail]  <= issue_pre_j;
        tail         <= tail + 1'b1;
      end
      count <= count + (ROB_W+1)'(issue_ok) - (ROB_W+1)'(commit_ok);
      if (commit_ok && head_flush) begin
        head <= '0; tail <= '0; count <= '0;
        busy <= '0; ready <= '0;
      end
    end
  end
endmodule

// File: tb/tb_rob_param.sv
// Randomized bench for rob_param against a queue/array level reference model,
// plus directed scenarios with literal expectations.
module tb_rob_param;
  localparam int RW = 4, NP = 2, AW = 32, DW = 32, GW = 5, D = 16;
  localparam logic [6:0] ALU = 7'b0110011, LD = 7'b0000011, ST = 7'b0100011,
                         BR = 7'b1100011, JR = 7'b1100111;

  logic clk = 1'b0, rst = 1'b1, rdy = 1'b1;
  logic issue_valid = 1'b0, issue_pre_j = 1'b0;
  logic [AW-1:0] issue_pc = '0;
  logic [6:0] issue_opcode = ALU;
  logic [GW-1:0] issue_rd = '0;
  logic [RW-1:0] issue_tag, head_tag, commit_tag, q1_tag = '0, q2_tag = '0;
  logic full, empty, q1_ready, q2_ready, commit_reg, commit_store, commit_br, commit_br_j, rollback;
  logic [RW:0] count;
  logic [NP-1:0] wb_valid = '0, wb_j = '0;
  logic [NP*RW-1:0] wb_tag = '0;
  logic [NP*DW-1:0] wb_val = '0;
  logic [NP*AW-1:0] wb_pc = '0;
  logic [DW-1:0] q1_val, q2_val, commit_val;
  logic [GW-1:0] commit_rd;
  logic [AW-1:0] commit_br_pc, rollback_pc;

  rob_param #(.ROB_W(RW), .WB_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .REG_W(GW)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .issue_valid(issue_valid), .issue_pc(issue_pc), .issue_opcode(issue_opcode),
    .issue_rd(issue_rd), .issue_pre_j(issue_pre_j), .issue_tag(issue_tag),
    .full(full), .empty(empty), .count(count), .head_tag(head_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_val(wb_val), .wb_j(wb_j), .wb_pc(wb_pc),
    .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_val(q1_val), .q2_val(q2_val),
    .commit_reg(commit_reg), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_tag(commit_tag), .commit_store(commit_store), .commit_br(commit_br),
    .commit_br_j(commit_br_j), .commit_br_pc(commit_br_pc),
    .rollback(rollback), .rollback_pc(rollback_pc));

  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: in-flight window is [m_head, m_head+m_count) modulo D.
  int m_head = 0, m_count = 0;
  logic m_ready [D], m_resj [D], m_prej [D];
  logic [31:0] m_pc [D], m_val [D], m_respc [D];
  logic [6:0] m_op [D];
  logic [4:0] m_rd [D];
  logic e_reg = 0, e_store = 0, e_br = 0, e_brj = 0, e_rb = 0;
  logic [4:0] e_rd = 0;
  logic [31:0] e_val = 0, e_brpc = 0, e_rbpc = 0;
  logic [3:0] e_tag = 0;
  bit was_rb, iss, com, fl;
  int t, h;

  always @(posedge clk) begin
    if (rst) begin
      m_head = 0; m_count = 0;
      for (int i = 0; i < D; i++) begin m_ready[i] = 0; m_val[i] = 0; end
      e_reg = 0; e_store = 0; e_br = 0; e_brj = 0; e_rb = 0;
      e_rd = 0; e_val = 0; e_brpc = 0; e_rbpc = 0; e_tag = 0;
    end else if (rdy) begin
      was_rb = e_rb;
      h = m_head;
      t = (m_head + m_count) % D;
      iss = issue_valid && m_count < D && !was_rb;
      com = m_count > 0 && m_ready[h] && !was_rb;
      fl = 0;
      e_reg = 0; e_store = 0; e_br = 0; e_rb = 0;
      if (com) begin
        e_tag = 4'(h);
        if (m_op[h] == ST) e_store = 1;
        else if (m_op[h] == BR) begin
          e_br = 1; e_brj = m_resj[h]; e_brpc = m_pc[h];
          if (m_resj[h] != m_prej[h]) begin fl = 1; e_rb = 1; e_rbpc = m_respc[h]; end
        end else begin
          e_reg = 1; e_rd = m_rd[h]; e_val = m_val[h];
          if (m_op[h] == JR) begin fl = 1; e_rb = 1; e_rbpc = m_respc[h]; end
        end
      end
      if (!was_rb)
        for (int p = NP - 1; p >= 0; p--)
          if (wb_valid[p]) begin
            m_ready[wb_tag[p*RW +: RW]] = 1;
            m_val[wb_tag[p*RW +: RW]]   = wb_val[p*DW +: DW];
            m_resj[wb_tag[p*RW +: RW]]  = wb_j[p];
            m_respc[wb_tag[p*RW +: RW]] = wb_pc[p*AW +: AW];
          end
      if (iss) begin
        m_ready[t] = (issue_opcode == ST); m_op[t] = issue_opcode; m_pc[t] = issue_pc;
        m_rd[t] = issue_rd; m_prej[t] = issue_pre_j;
      end
      m_count = m_count + int'(iss) - int'(com);
      if (com) m_head = (m_head + 1) % D;
      if (fl) begin
        m_head = 0; m_count = 0;
        for (int i = 0; i < D; i++) m_ready[i] = 0;
      end
    end
  end

  function automatic logic [32:0] exp_lookup(input logic [3:0] tg);
    logic r;
    logic [31:0] v;
    r = m_ready[tg];
    v = m_val[tg];
    for (int p = NP - 1; p >= 0; p--)
      if (wb_valid[p] && wb_tag[p*RW +: RW] == tg) begin r = 1; v = wb_val[p*DW +: DW]; end
    return {r, v};
  endfunction

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("count", 64'(count), 64'(m_count));
      check("empty", 64'(empty), 64'(m_count == 0));
      check("full", 64'(full), 64'(m_count == D));
      check("issue_tag", 64'(issue_tag), 64'((m_head + m_count) % D));
      check("head_tag", 64'(head_tag), 64'(m_head));
      check("commit_pulses", 64'({commit_reg, commit_store, commit_br, rollback}),
            64'({e_reg, e_store, e_br, e_rb}));
      if (e_reg) check("commit_reg_data", {27'b0, commit_rd, commit_val}, {27'b0, e_rd, e_val});
      if (e_reg || e_store || e_br) check("commit_tag", 64'(commit_tag), 64'(e_tag));
      if (e_br) check("commit_br_data", 64'({commit_br_j, commit_br_pc}), 64'({e_brj, e_brpc}));
      if (e_rb) check("rollback_pc", 64'(rollback_pc), 64'(e_rbpc));
      check("q1_lookup", 64'({q1_ready, q1_val}), 64'(exp_lookup(q1_tag)));
      check("q2_lookup", 64'({q2_ready, q2_val}), 64'(exp_lookup(q2_tag)));
    end
  end

  task automatic tick(); @(posedge clk); #3; endtask
  task automatic idle(); issue_valid = 0; wb_valid = '0; endtask
  task automatic do_reset(); idle(); rst = 1; tick(); tick(); rst = 0; endtask
  task automatic set_issue(input logic [6:0] op, input int r, input int pcv, input bit pj);
    issue_valid = 1; issue_opcode = op; issue_rd = 5'(r); issue_pc = 32'(pcv); issue_pre_j = pj;
  endtask
  task automatic set_wb(input int p, input int tg, input int v, input bit j, input int pcv);
    wb_valid[p] = 1; wb_tag[p*RW +: RW] = 4'(tg); wb_val[p*DW +: DW] = 32'(v);
    wb_j[p] = j; wb_pc[p*AW +: AW] = 32'(pcv);
  endtask

  int tg;
  initial begin
    do_reset();
    check("rst_count", 64'(count), 0);
    check("rst_flags", 64'({empty, full, issue_tag, head_tag}), 64'({1'b1, 1'b0, 4'd0, 4'd0}));
    check("rst_pulses", 64'({commit_reg, commit_store, commit_br, rollback}), 0);

    // Out-of-order writeback, in-order commit.
    for (int i = 1; i <= 3; i++) begin set_issue(ALU, i, 4 * i, 0); tick(); end
    check("three_issued", 64'({count, issue_tag}), 64'({5'd3, 4'd3}));
    idle(); set_wb(0, 2, 'h30, 0, 0); set_wb(1, 0, 'h10, 0, 0); tick();
    check("no_commit_yet", 64'(commit_reg), 0);
    idle(); set_wb(0, 1, 'h20, 0, 0); tick();
    check("commit1", 64'({commit_reg, commit_rd, commit_val, commit_tag}), 64'({1'b1, 5'd1, 32'h10, 4'd0}));
    idle(); tick();
    check("commit2", 64'({commit_reg, commit_rd, commit_val}), 64'({1'b1, 5'd2, 32'h20}));
    tick();
    check("commit3", 64'({commit_reg, commit_rd, commit_val}), 64'({1'b1, 5'd3, 32'h30}));
    check("drained", 64'({empty, count}), 64'({1'b1, 5'd0}));

    // Fill to capacity, drop while full, wrap-around allocation.
    do_reset();
    for (int i = 0; i < D; i++) begin set_issue(ALU, i, i, 0); tick(); end
    check("full16", 64'({full, count, issue_tag}), 64'({1'b1, 5'd16, 4'd0}));
    tick();
    check("drop17", 64'({count, issue_tag}), 64'({5'd16, 4'd0}));
    set_wb(0, 0, 'h99, 0, 0); tick();
    wb_valid = '0; tick();
    check("drop_on_commit", 64'({commit_reg, count, issue_tag}), 64'({1'b1, 5'd15, 4'd0}));
    tick();
    check("wrap_issue", 64'({count, issue_tag}), 64'({5'd16, 4'd1}));

    // Mispredicted branch flushes younger entries.
    do_reset();
    set_issue(BR, 0, 'h40, 0); tick();
    for (int i = 1; i <= 3; i++) begin set_issue(ALU, i, 'h40 + 4 * i, 0); tick(); end
    idle(); set_wb(0, 0, 0, 1, 'h1000); tick();
    wb_valid = '0; set_issue(ALU, 7, 'h50, 0); tick();
    check("br_commit", 64'({commit_br, commit_br_j, commit_br_pc, commit_reg}), 64'({1'b1, 1'b1, 32'h40, 1'b0}));
    check("br_rollback", 64'({rollback, rollback_pc}), 64'({1'b1, 32'h1000}));
    check("br_flushed", 64'({count, empty}), 64'({5'd0, 1'b1}));
    tick();
    check("rb_issue_ignored", 64'({count, rollback, issue_tag}), 64'({5'd0, 1'b0, 4'd0}));

    // JALR writes rd and redirects.
    set_issue(JR, 1, 'h200, 0); tick();
    idle(); set_wb(1, 0, 'h204, 0, 'h80); tick();
    idle(); tick();
    check("jalr", 64'({commit_reg, commit_rd, commit_val, rollback}), 64'({1'b1, 5'd1, 32'h204, 1'b1}));
    check("jalr_pc", 64'(rollback_pc), 64'h80);
    tick();

    // Store waits behind a pending load.
    set_issue(LD, 5, 'h300, 0); tick();
    set_issue(ST, 0, 'h304, 0); tick();
    idle(); tick(); tick();
    check("store_held", 64'({commit_store, commit_reg}), 0);
    set_wb(0, 0, 'h55, 0, 0); tick();
    idle(); tick();
    check("load_commit", 64'({commit_reg, commit_rd, commit_val, commit_store}), 64'({1'b1, 5'd5, 32'h55, 1'b0}));
    tick();
    check("store_commit", 64'({commit_store, commit_reg, commit_tag}), 64'({1'b1, 1'b0, 4'd1}));
    tick();
    check("store_pulse_end", 64'(commit_store), 0);

    // Two ports hit the same tag: lowest port wins for bypass and storage.
    set_wb(0, 5, 'hA, 0, 0); set_wb(1, 5, 'hB, 0, 0); q1_tag = 5; #1;
    check("bypass_prio", 64'({q1_ready, q1_val}), 64'({1'b1, 32'hA}));
    tick();
    idle(); #1;
    check("stored_prio", 64'({q1_ready, q1_val}), 64'({1'b1, 32'hA}));

    // Randomized traffic checked every cycle by the compare process.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      case ($urandom_range(0, 19))
        0, 1, 2, 3, 4, 5, 6, 7, 8: issue_opcode = ALU;
        9, 10, 11: issue_opcode = LD;
        12, 13, 14, 15: issue_opcode = ST;
        16, 17, 18: issue_opcode = BR;
        default: issue_opcode = JR;
      endcase
      issue_rd = 5'($urandom); issue_pc = $urandom; issue_pre_j = 1'($urandom);
      for (int p = 0; p < NP; p++) begin
        if (m_count > 0 && $urandom_range(0, 3) != 0) tg = (m_head + $urandom_range(0, m_count - 1)) % D;
        else tg = $urandom_range(0, D - 1);
        wb_valid[p] = ($urandom_range(0, 9) < 4);
        wb_tag[p*RW +: RW] = 4'(tg);
        wb_val[p*DW +: DW] = $urandom;
        wb_j[p] = 1'($urandom);
        wb_pc[p*AW +: AW] = $urandom;
      end
      q1_tag = 4'($urandom); q2_tag = 4'($urandom);
      tick();
    end
    rst = 0; rdy = 1; idle(); tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rob_param.md
# rob_param

Parametrised reorder buffer for the out-of-order RV32I core, sitting between the decoder/issue stage, the execution units (ALU, LSB, …) and the regfile/ifetch commit path. It allocates entries in program order, collects results from `WB_PORTS` writeback channels and retires one entry per cycle in order. It also provides two combinational operand-lookup ports with same-cycle writeback bypass, and performs a single-cycle flush on branch mispredict or JALR.

## Interface
Parameters:
- `ROB_W`, 4: tag width; depth `DEPTH = 2**ROB_W`.
- `WB_PORTS`, 2: number of writeback channels.
- `ADDR_W`, 32: PC width.
- `DATA_W`, 32: result width.
- `REG_W`, 5: architectural register index width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: global enable; when low, all state and registered outputs hold.
- `issue_valid` in 1: allocate request.
- `issue_pc` in ADDR_W: PC of the issuing instruction.
- `issue_opcode` in 7: opcode of the issuing instruction.
- `issue_rd` in REG_W: destination register.
- `issue_pre_j` in 1: predicted branch taken.
- `issue_tag` out ROB_W: tail index; this is the tag the current issue receives.
- `full` out 1: `count == DEPTH`.
- `empty` out 1: `count == 0`.
- `count` out ROB_W+1: occupancy.
- `head_tag` out ROB_W: oldest entry.
- `wb_valid` in WB_PORTS: per-port result valid.
- `wb_tag` in WB_PORTS*ROB_W: per-port target tag, packed with port p at `[p*ROB_W +: ROB_W]`.
- `wb_val` in WB_PORTS*DATA_W: per-port result value, packed the same way.
- `wb_j` in WB_PORTS: per-port actual taken.
- `wb_pc` in WB_PORTS*ADDR_W: per-port resolved target PC.
- `q1_tag`, `q2_tag` in ROB_W: operand lookup tags.
- `q1_ready`, `q2_ready` out 1: looked-up value is available.
- `q1_val`, `q2_val` out DATA_W: looked-up value.
- `commit_reg` out 1: regfile write pulse.
- `commit_rd` out REG_W: regfile destination.
- `commit_val` out DATA_W: regfile value.
- `commit_tag` out ROB_W: tag of the retiring entry.
- `commit_store` out 1: store-release pulse to the LSB.
- `commit_br` out 1: predictor update pulse.
- `commit_br_j` out 1: actual branch outcome.
- `commit_br_pc` out ADDR_W: PC of the committed branch.
- `rollback` out 1: flush pulse.
- `rollback_pc` out ADDR_W: redirect target.

## Operation
- **Entry fields:** `busy`, `ready`, `pc`, `opcode`, `rd`, `val`, `res_j`, `res_pc`, `pre_j`. Pointers `head` and `tail` wrap modulo DEPTH; `count` is kept explicitly.
- **Issue:**
  - Accepted when `issue_valid && !full && !rollback`.
  - Writes the entry at `tail` and increments `tail`.
  - `ready` is set to 1 for `OPCODE_S` (1100011→no, 0100011 yes) and to 0 otherwise.
- **Writeback:**
  - A port with `wb_valid[p]` sets `ready`, `val`, `res_j` and `res_pc` of entry `wb_tag[p]`.
  - If two ports target the same tag, the lowest port index wins.
  - An issue to the same index in the same cycle overrides the writeback.
- **Commit:**
  - Occurs when `!empty && ready[head] && !rollback`; `head` then increments.
  - Decode of `opcode[head]`:
    - 0100011 (S): `commit_store`=1.
    - 1100011 (B): `commit_br`=1, `commit_br_j`=`res_j`, `commit_br_pc`=`pc`. If `res_j != pre_j`, also `rollback`=1 and `rollback_pc`=`res_pc`.
    - 1100111 (JALR): `commit_reg`=1 with `rd`/`val`, plus `rollback`=1 and `rollback_pc`=`res_pc`.
    - Any other opcode: `commit_reg`=1 with `rd`/`val`.
  - `commit_tag` is set to `head` on every commit.
- **Flush:** on the edge that raises `rollback`, `head`, `tail` and `count` reset to 0 and all `busy`/`ready` bits clear.
- **Count update:** `count` changes by issue_accepted − commit. A simultaneous issue and commit leaves `count` unchanged.
- **Lookup (combinational):**
  - `qN_ready` = `ready[qN_tag]` OR any `wb_valid[p]` with `wb_tag[p]==qN_tag`.
  - `qN_val` uses the matching writeback value (lowest port first) when one exists, else the stored `val`.

## Timing
- **Reset:** all outputs 0; `empty`=1, `full`=0, `count`=0, `issue_tag`=0, `head_tag`=0; all entries not busy.
- **Issue latency:** an entry issued at edge N is visible in `count`/`full` from cycle N+1.
- **Writeback latency:** a writeback at edge N makes the entry committable in cycle N+1. Commit outputs are registered, so they appear one cycle after the commit decision (cycle N+2 relative to the writeback edge).
- **Pulse outputs:** `commit_*` and `rollback` are high for exactly one cycle per event; `rdy` low stretches them.
- **Rollback cycle:** while `rollback`=1 (the cycle after the flush edge), issue and writeback inputs are ignored and no commit occurs.
- **Full:** derived from registered `count`. An issue while `full`=1 is dropped even if a commit happens in the same cycle.
- **Wrap-around:** `tail`/`head` go from DEPTH−1 to 0; tags are reused only after retirement.
- **Reset mid-operation:** `rst` overrides `rollback`, issue, writeback and commit in the same cycle.

## Test plan
- Reset, then issue 3 ALU ops (rd=1,2,3); write back tags 2,0,1 with vals 0x30,0x10,0x20 → commits in order rd1=0x10, rd2=0x20, rd3=0x30, one per cycle.
- Issue 16 ops with `ROB_W`=4 and no writeback → `full`=1 and `count`=16; a 17th issue is dropped (`issue_tag` stays 0). After one commit, an issue is accepted at tag 0 (wrap-around).
- Branch with `pre_j`=0, writeback `res_j`=1 and `res_pc`=0x1000, with 3 younger entries → `commit_br`=1 and `rollback`=1 with `rollback_pc`=0x1000; the next cycle shows `count`=0 and `empty`=1, and an issue during the rollback cycle is ignored.
- JALR with rd=1, `val`=0x204, `res_pc`=0x80 → `commit_reg` (rd1=0x204) and `rollback` to 0x80 in the same cycle.
- Store issued behind a pending load → `commit_store` pulses only after the load commits, with no `commit_reg` for the store.
- Port 0 and port 1 write tag 5 with 0xA and 0xB while `q1_tag`=5 → `q1_ready`=1 and `q1_val`=0xA in the same cycle; the stored `val` is 0xA.
